cdb_arbiter: RTL and testbench

//   Collects completed results from NUM_SOURCES functional units and drives the shared common data bus (CDB).

---
 rtl/cdb_arbiter.sv | 106 ++++++++++
 tb/tb_cdb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding buffer per result source, round-robin
// selection of at most one buffered result per cycle onto a registered CDB.
module cdb_arbiter #(
    parameter int NUM_SOURCES   = 2,
    parameter int DATA_WIDTH    = 4,
    parameter int CDB_TAG_WIDTH = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_SOURCES-1:0]                 src_valid,
    output logic [NUM_SOURCES-1:0]                 src_ready,
    input  logic [NUM_SOURCES*CDB_TAG_WIDTH-1:0]   src_tag,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]      src_data,
    output logic                                   cdb_out_valid,
    output logic [CDB_TAG_WIDTH-1:0]               cdb_out_tag,
    output logic [DATA_WIDTH-1:0]                  cdb_out_data
);

    localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [NUM_SOURCES-1:0]   buf_valid_reg;
    logic [CDB_TAG_WIDTH-1:0] buf_tag_reg  [NUM_SOURCES];
    logic [DATA_WIDTH-1:0]    buf_data_reg [NUM_SOURCES];
    logic [PTR_W-1:0]         rr_ptr_reg;
    logic [PTR_W-1:0]         rr_ptr_next;

    logic [NUM_SOURCES-1:0]   grant;
    logic [NUM_SOURCES-1:0]   accept;
    logic [PTR_W-1:0]         winner;
    logic                     any_full;

    assign any_full = |buf_valid_reg;

    // First full buffer at or after rr_ptr, wrapping around.
    always_comb begin
        int  idx;
        logic found;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_SOURCES;
            if (!found && buf_valid_reg[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        if (int'(winner) == NUM_SOURCES - 1) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = winner + PTR_W'(1);
        end
    end

    // A buffer being drained this cycle can take a new result at the same edge.
    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            assign src_ready[gi] = !buf_valid_reg[gi] || grant[gi];
            assign accept[gi]    = src_valid[gi] && src_ready[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_reg <= '0;
            for (int i = 0; i < NUM_SOURCES; i++) begin
                buf_tag_reg[i]  <= '0;
                buf_data_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SOURCES; i++) begin
                if (accept[i]) begin
                    buf_valid_reg[i] <= 1'b1;
                    buf_tag_reg[i]   <= src_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
                    buf_data_reg[i]  <= src_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (grant[i]) begin
                    buf_valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_out_valid <= 1'b0;
            cdb_out_tag   <= '0;
            cdb_out_data  <= '0;
            rr_ptr_reg    <= '0;
        end else if (any_full) begin
            cdb_out_valid <= 1'b1;
            cdb_out_tag   <= buf_tag_reg[winner];
            cdb_out_data  <= buf_data_reg[winner];
            rr_ptr_reg    <= rr_ptr_next;
        end else begin
            cdb_out_valid <= 1'b0;
            cdb_out_tag   <= '0;
            cdb_out_data  <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and scoreboard checks of cdb_arbiter with two sources.
module tb_cdb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] src_valid = '0;
    logic [1:0] src_ready;
    logic [7:0] src_tag = '0;
    logic [7:0] src_data = '0;
    logic       cdb_out_valid;
    logic [3:0] cdb_out_tag;
    logic [3:0] cdb_out_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_SOURCES(2), .DATA_WIDTH(4), .CDB_TAG_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_data(src_data),
        .cdb_out_valid(cdb_out_valid), .cdb_out_tag(cdb_out_tag),
        .cdb_out_data(cdb_out_data)
    );

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cdb(input string name, input logic v, input logic [3:0] t, input logic [3:0] d);
        check_eq({name, "_v"}, {31'd0, cdb_out_valid}, {31'd0, v});
        check_eq({name, "_tag"}, {28'd0, cdb_out_tag}, {28'd0, t});
        check_eq({name, "_data"}, {28'd0, cdb_out_data}, {28'd0, d});
    endtask

    task automatic do_reset();
        src_valid = '0;
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
    endtask

    logic       pending [16];
    logic [3:0] exp_data [16];
    int         tag_cnt;
    int         n0;
    int         n1;

    initial begin
        // Reset state
        #2;
        check_cdb("rst", 1'b0, 4'h0, 4'h0);
        check_eq("rst_ready", {30'd0, src_ready}, 32'h3);
        #2 rst_n = 1'b1;
        tick();

        // 1) reset while both buffers are full and the CDB is busy
        src_valid = 2'b11; src_tag = 8'hBA; src_data = 8'hDC;
        tick();
        tick();
        check_eq("t1_busy_v", {31'd0, cdb_out_valid}, 32'h1);
        check_eq("t1_busy_ready", {30'd0, src_ready}, 32'h2);
        src_valid = '0;
        rst_n = 1'b0;
        #1;
        check_cdb("t1_async", 1'b0, 4'h0, 4'h0);
        check_eq("t1_ready", {30'd0, src_ready}, 32'h3);
        #2 rst_n = 1'b1;
        tick();
        check_eq("t1_after1_v", {31'd0, cdb_out_valid}, 32'h0);
        tick();
        check_eq("t1_after2_v", {31'd0, cdb_out_valid}, 32'h0);

        // 2) single result, one-cycle minimum latency
        src_valid = 2'b01; src_tag = 8'h03; src_data = 8'h09;
        tick();
        src_valid = '0;
        check_eq("t2_edge_k_v", {31'd0, cdb_out_valid}, 32'h0);
        tick();
        check_cdb("t2_bcast", 1'b1, 4'h3, 4'h9);
        tick();
        check_eq("t2_once_v", {31'd0, cdb_out_valid}, 32'h0);

        // 3) simultaneous offers from rr_ptr=0
        do_reset();
        src_valid = 2'b11; src_tag = 8'h21; src_data = 8'h65;
        tick();
        src_valid = '0;
        tick();
        check_cdb("t3_first", 1'b1, 4'h1, 4'h5);
        tick();
        check_cdb("t3_second", 1'b1, 4'h2, 4'h6);
        tick();
        check_eq("t3_idle_v", {31'd0, cdb_out_valid}, 32'h0);

        // 4) sole source streams at full rate
        for (int i = 0; i < 4; i++) begin
            src_valid = 2'b10;
            src_tag   = {4'(4 + i), 4'h0};
            src_data  = {4'(8 + i), 4'h0};
            check_eq($sformatf("t4_ready%0d", i), {31'd0, src_ready[1]}, 32'h1);
            tick();
            if (i > 0) check_cdb($sformatf("t4_b%0d", i - 1), 1'b1, 4'(3 + i), 4'(7 + i));
        end
        src_valid = '0;
        tick();
        check_cdb("t4_b3", 1'b1, 4'h7, 4'hB);
        tick();
        check_eq("t4_idle_v", {31'd0, cdb_out_valid}, 32'h0);

        // 5) both always valid: alternating grants, ready toggles
        do_reset();
        n0 = 0; n1 = 0;
        for (int c = 0; c < 8; c++) begin
            src_valid = 2'b11;
            src_tag   = {4'(8 + n1), 4'(n0)};
            src_data  = {4'(8 + n1) ^ 4'hF, 4'(n0) ^ 4'hF};
            check_eq($sformatf("t5_ready%0d", c), {30'd0, src_ready},
                     (c == 0) ? 32'h3 : ((c % 2 == 1) ? 32'h1 : 32'h2));
            if (src_ready[0]) n0++;
            if (src_ready[1]) n1++;
            tick();
            if (c >= 1) begin
                if ((c - 1) % 2 == 0)
                    check_cdb($sformatf("t5_b%0d", c - 1), 1'b1, 4'((c - 1) / 2), 4'((c - 1) / 2) ^ 4'hF);
                else
                    check_cdb($sformatf("t5_b%0d", c - 1), 1'b1, 4'(8 + (c - 1) / 2), 4'(8 + (c - 1) / 2) ^ 4'hF);
            end
        end

        // 6) random traffic against a tag scoreboard
        do_reset();
        for (int t = 0; t < 16; t++) begin
            pending[t] = 1'b0;
            exp_data[t] = '0;
        end
        tag_cnt = 0;
        for (int c = 0; c < 240; c++) begin
            logic [3:0] t0, t1;
            logic [3:0] d0, d1;
            if (cdb_out_valid) begin
                check_eq("t6_once", {31'd0, pending[cdb_out_tag]}, 32'h1);
                check_eq("t6_data", {28'd0, cdb_out_data}, {28'd0, exp_data[cdb_out_tag]});
                pending[cdb_out_tag] = 1'b0;
            end
            if (c < 220) src_valid = 2'($urandom_range(0, 3));
            else src_valid = '0;
            t0 = 4'(tag_cnt); t1 = 4'(tag_cnt + 1);
            d0 = 4'($urandom); d1 = 4'($urandom);
            src_tag = {t1, t0}; src_data = {d1, d0};
            #1;
            if (src_valid[0] && src_ready[0]) begin
                pending[t0] = 1'b1; exp_data[t0] = d0;
            end
            if (src_valid[1] && src_ready[1]) begin
                pending[t1] = 1'b1; exp_data[t1] = d1;
            end
            if (|(src_valid & src_ready)) tag_cnt = (tag_cnt + 2) % 16;
            tick();
        end
        begin
            int left;
            left = 0;
            for (int t = 0; t < 16; t++) if (pending[t]) left++;
            check_eq("t6_all_seen", left, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
